// File: rtl/sample_dac_tx.sv
// sample_dac_tx
//
// Sink for the tone generator's mixed-sample stream. Each 16-bit sample
// strobed in on data_valid_in is sent to an external serial DAC as one
// I2S-style stereo frame: the mono sample is sent MSB first on the left
// channel (lrck=0), then again on the right channel (lrck=1). Data and
// lrck change only on falling edges of bclk. A one-entry pending buffer
// holds a sample that arrives mid-frame. When a sample is dropped, a
// sticky overrun flag is set.
//
// Optional build macro:
//   OFFSET_BINARY_EN - when defined, the sample MSB is inverted on capture.
//                      This converts two's complement to offset binary for
//                      unsigned DACs. Timing is unchanged.
//
// Parameters:
//   BCLK_DIV       system clocks per bclk half-period (1..255)
//
// Ports:
//   clk_in         system clock
//   reset_n_in     asynchronous active-low reset
//   data_in        sample word, sampled only while data_valid_in=1
//   data_valid_in  one-cycle sample strobe
//   dac_bclk_out   serial bit clock (DAC samples on rising edge)
//   dac_lrck_out   word select, 0 = left, 1 = right
//   dac_data_out   serial data, MSB first
//   busy_out       high while a frame is being shifted
//   overrun_out    sticky, a sample was dropped; cleared only by reset

module sample_dac_tx #(
    parameter int BCLK_DIV = 8
) (
    input  logic        clk_in,
    input  logic        reset_n_in,
    input  logic [15:0] data_in,
    input  logic        data_valid_in,
    output logic        dac_bclk_out,
    output logic        dac_lrck_out,
    output logic        dac_data_out,
    output logic        busy_out,
    output logic        overrun_out
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

    state_t      state_q, state_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  div_q, div_d;
    logic [4:0]  bit_q, bit_d;
    logic        bclk_q, bclk_d;
    logic        lrck_q, lrck_d;
    logic [15:0] pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        ovr_q, ovr_d;

    logic        div_tc;
    logic        bclk_fall;
    logic        frame_end;
    logic        load;
    logic [15:0] load_word;
    logic [4:0]  bit_inc;

    function automatic logic [15:0] capture(input logic [15:0] s);
`ifdef OFFSET_BINARY_EN
        return {~s[15], s[14:0]};
`else
        return s;
`endif
    endfunction

    assign div_tc    = (state_q == SHIFT) && (div_q == DIV_LAST);
    // bclk is high when the divider wraps, so this wrap drives bclk low.
    assign bclk_fall = div_tc && bclk_q;
    assign frame_end = bclk_fall && (bit_q == 5'd31);
    assign bit_inc   = bit_q + 5'd1;

    // State register
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (data_valid_in) state_d = SHIFT;
            SHIFT:   if (frame_end && !data_valid_in && !pend_vld_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next-state: divider, bit counter, shifter, pending buffer
    always_comb begin
        shift_d    = shift_q;
        div_d      = div_q;
        bit_d      = bit_q;
        bclk_d     = bclk_q;
        lrck_d     = lrck_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovr_d      = ovr_q;
        load       = 1'b0;
        load_word  = capture(data_in);

        case (state_q)
            IDLE: begin
                if (data_valid_in) load = 1'b1;
            end
            SHIFT: begin
                if (div_tc) begin
                    div_d  = 8'd0;
                    bclk_d = ~bclk_q;
                end else begin
                    div_d  = div_q + 8'd1;
                end

                if (frame_end) begin
                    // A fresh strobe takes precedence over the buffered
                    // sample. The buffered sample is then lost.
                    if (data_valid_in) begin
                        load = 1'b1;
                        if (pend_vld_q) ovr_d = 1'b1;
                    end else if (pend_vld_q) begin
                        load      = 1'b1;
                        load_word = pend_q;
                    end else begin
                        shift_d = 32'd0;
                        bclk_d  = 1'b0;
                        lrck_d  = 1'b0;
                        div_d   = 8'd0;
                        bit_d   = 5'd0;
                    end
                end else begin
                    if (bclk_fall) begin
                        bit_d   = bit_inc;
                        shift_d = {shift_q[30:0], 1'b0};
                        lrck_d  = bit_inc[4];
                    end
                    if (data_valid_in) begin
                        pend_d     = capture(data_in);
                        pend_vld_d = 1'b1;
                        if (pend_vld_q) ovr_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        if (load) begin
            shift_d    = {load_word, load_word};
            bclk_d     = 1'b0;
            lrck_d     = 1'b0;
            div_d      = 8'd0;
            bit_d      = 5'd0;
            pend_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            shift_q    <= 32'd0;
            div_q      <= 8'd0;
            bit_q      <= 5'd0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b0;
            pend_q     <= 16'd0;
            pend_vld_q <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            shift_q    <= shift_d;
            div_q      <= div_d;
            bit_q      <= bit_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovr_q      <= ovr_d;
        end
    end

    // Outputs. The serial bit is the shifter MSB, which is cleared in IDLE.
    always_comb begin
        busy_out     = (state_q == SHIFT);
        dac_bclk_out = bclk_q;
        dac_lrck_out = lrck_q;
        dac_data_out = shift_q[31];
        overrun_out  = ovr_q;
    end

endmodule

// File: tb/tb_sample_dac_tx.sv
module tb_sample_dac_tx;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] din;
    logic [2:0]  vld;
    logic [2:0]  bclk, lrck, sdat, busy, ovr;

    // Instance 0: BCLK_DIV=1, instance 1: BCLK_DIV=2, instance 2: BCLK_DIV=8
    sample_dac_tx #(.BCLK_DIV(1)) u_div1 (
        .clk_in(clk), .reset_n_in(rst_n), .data_in(din), .data_valid_in(vld[0]),
        .dac_bclk_out(bclk[0]), .dac_lrck_out(lrck[0]), .dac_data_out(sdat[0]),
        .busy_out(busy[0]), .overrun_out(ovr[0]));
    sample_dac_tx #(.BCLK_DIV(2)) u_div2 (
        .clk_in(clk), .reset_n_in(rst_n), .data_in(din), .data_valid_in(vld[1]),
        .dac_bclk_out(bclk[1]), .dac_lrck_out(lrck[1]), .dac_data_out(sdat[1]),
        .busy_out(busy[1]), .overrun_out(ovr[1]));
    sample_dac_tx #(.BCLK_DIV(8)) u_div8 (
        .clk_in(clk), .reset_n_in(rst_n), .data_in(din), .data_valid_in(vld[2]),
        .dac_bclk_out(bclk[2]), .dac_lrck_out(lrck[2]), .dac_data_out(sdat[2]),
        .busy_out(busy[2]), .overrun_out(ovr[2]));

`ifdef OFFSET_BINARY_EN
    localparam logic [31:0] OB_MASK = 32'h8000_8000;
`else
    localparam logic [31:0] OB_MASK = 32'h0000_0000;
`endif

    int   checks = 0;
    int   errors = 0;
    logic [1:0] sel = 2'd0;
    logic mon_clr = 1'b1;

    logic m_bclk, m_lrck, m_data, m_busy, m_ovr;
    always_comb begin
        m_bclk = bclk[sel];
        m_lrck = lrck[sel];
        m_data = sdat[sel];
        m_busy = busy[sel];
        m_ovr  = ovr[sel];
    end

    // Frame monitor: collects serial bits on bclk rising edges.
    logic [31:0] cur_d, cur_l;
    logic [31:0] fr_d [0:3];
    logic [31:0] fr_l [0:3];
    int nbits, frames, busy_len, runs, last_run, since, pmin, pmax, glitches;
    logic seen_rise, prev_b, prev_d, prev_l, prev_busy;

    always @(negedge clk) begin
        if (mon_clr) begin
            cur_d = '0; cur_l = '0; nbits = 0; frames = 0; busy_len = 0;
            runs = 0; last_run = 0; since = 0; pmin = 1000000; pmax = 0;
            glitches = 0; seen_rise = 1'b0; prev_b = 1'b0; prev_d = 1'b0;
            prev_l = 1'b0; prev_busy = 1'b0;
            for (int i = 0; i < 4; i++) begin
                fr_d[i] = '0;
                fr_l[i] = '0;
            end
        end else begin
            since++;
            if (m_busy) busy_len++;
            if (prev_busy && !m_busy) begin
                runs++;
                last_run = busy_len;
                busy_len = 0;
            end
            if (m_bclk && !prev_b) begin
                if (seen_rise) begin
                    if (since < pmin) pmin = since;
                    if (since > pmax) pmax = since;
                end
                seen_rise = 1'b1;
                since = 0;
                cur_d = {cur_d[30:0], m_data};
                cur_l = {cur_l[30:0], m_lrck};
                nbits++;
                if (nbits == 32) begin
                    if (frames < 4) begin
                        fr_d[frames] = cur_d;
                        fr_l[frames] = cur_l;
                    end
                    frames++;
                    nbits = 0;
                end
            end
            if (((m_data != prev_d) || (m_lrck != prev_l)) &&
                !(prev_b && !m_bclk) && !(m_busy && !prev_busy))
                glitches++;
            prev_b = m_bclk; prev_d = m_data; prev_l = m_lrck; prev_busy = m_busy;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mon_clr = 1'b1;
        vld = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {27'd0, m_busy, m_bclk, m_lrck, m_data, m_ovr}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [15:0] d);
        din = d;
        vld = 3'b001 << sel;
        @(posedge clk);
        #1;
        vld = '0;
        din = 16'hDEAD;
    endtask

    typedef struct {
        logic [1:0]  sel;
        logic        rst;
        logic [15:0] d;
        logic [31:0] exp_plain;
        int          exp_run;
        int          exp_per;
    } vec_t;

    vec_t vecs [0:5];

    initial begin
        rst_n = 1'b0;
        din   = '0;
        vld   = '0;

        vecs[0] = '{2'd1, 1'b1, 16'hA5C3, 32'hA5C3_A5C3, 128, 4};
        vecs[1] = '{2'd2, 1'b1, 16'h0001, 32'h0001_0001, 512, 16};
        vecs[2] = '{2'd2, 1'b0, 16'hFFFF, 32'hFFFF_FFFF, 512, 16};
        vecs[3] = '{2'd0, 1'b1, 16'h8000, 32'h8000_8000, 64, 2};
        vecs[4] = '{2'd0, 1'b0, 16'h7FFF, 32'h7FFF_7FFF, 64, 2};
        vecs[5] = '{2'd1, 1'b0, 16'h3C96, 32'h3C96_3C96, 128, 4};

        do_reset();

        // Single frames, each strobe 1024 clocks apart.
        for (int v = 0; v < 6; v++) begin
            logic [31:0] exp;
            exp = vecs[v].exp_plain ^ OB_MASK;
            sel = vecs[v].sel;
            if (vecs[v].rst) do_reset();
            else clr_mon();
            chk("idle_before", {31'd0, m_busy}, 32'd0);
            strobe(vecs[v].d);
            chk("busy_start", {31'd0, m_busy}, 32'd1);
            chk("first_bit", {31'd0, m_data}, {31'd0, exp[31]});
            repeat (1022) @(posedge clk);
            #1;
            chk("frame_count", frames, 1);
            chk("frame_data", fr_d[0], exp);
            chk("frame_lrck", fr_l[0], 32'h0000_FFFF);
            chk("busy_run", last_run, vecs[v].exp_run);
            chk("bclk_pmin", pmin, vecs[v].exp_per);
            chk("bclk_pmax", pmax, vecs[v].exp_per);
            chk("edge_align", glitches, 0);
            chk("overrun_clear", {31'd0, m_ovr}, 32'd0);
            chk("idle_after", {28'd0, m_busy, m_bclk, m_lrck, m_data}, 32'd0);
        end

        // Back-to-back frames through the pending buffer.
        sel = 2'd0;
        do_reset();
        strobe(16'h1234);
        repeat (8) @(posedge clk);
        #1;
        strobe(16'h5678);
        chk("b2b_busy_mid", {31'd0, m_busy}, 32'd1);
        repeat (200) @(posedge clk);
        #1;
        chk("b2b_frames", frames, 2);
        chk("b2b_f0", fr_d[0], 32'h1234_1234 ^ OB_MASK);
        chk("b2b_f1", fr_d[1], 32'h5678_5678 ^ OB_MASK);
        chk("b2b_runs", runs, 1);
        chk("b2b_run_len", last_run, 128);
        chk("b2b_overrun", {31'd0, m_ovr}, 32'd0);
        chk("b2b_align", glitches, 0);

        // Overrun: newest pending sample wins.
        do_reset();
        strobe(16'h1111);
        repeat (3) @(posedge clk);
        #1;
        strobe(16'h2222);
        chk("ovr_after_2nd", {31'd0, m_ovr}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        strobe(16'h3333);
        chk("ovr_after_3rd", {31'd0, m_ovr}, 32'd1);
        repeat (200) @(posedge clk);
        #1;
        chk("ovr_frames", frames, 2);
        chk("ovr_f0", fr_d[0], 32'h1111_1111 ^ OB_MASK);
        chk("ovr_f1", fr_d[1], 32'h3333_3333 ^ OB_MASK);
        chk("ovr_sticky", {31'd0, m_ovr}, 32'd1);

        // Strobe coincident with frame end while a sample is pending.
        do_reset();
        strobe(16'hAAAA);
        repeat (9) @(posedge clk);
        #1;
        strobe(16'hBBBB);
        repeat (53) @(posedge clk);
        #1;
        strobe(16'hCCCC);
        chk("fe_overrun", {31'd0, m_ovr}, 32'd1);
        repeat (200) @(posedge clk);
        #1;
        chk("fe_frames", frames, 2);
        chk("fe_f1", fr_d[1], 32'hCCCC_CCCC ^ OB_MASK);
        chk("fe_run_len", last_run, 128);

        // Reset mid-frame with a pending sample.
        sel = 2'd1;
        do_reset();
        strobe(16'hA5C3);
        repeat (4) @(posedge clk);
        #1;
        strobe(16'h0F0F);
        begin
            int n;
            n = 0;
            while (nbits < 7 && n < 200) begin
                @(posedge clk);
                #1;
                n++;
            end
            chk("mid_reach_bit7", {31'd0, (n < 200)}, 32'd1);
        end
        @(negedge clk);
        #1;
        chk("mid_busy_before", {31'd0, m_busy}, 32'd1);
        rst_n = 1'b0;
        mon_clr = 1'b1;
        #1;
        chk("mid_async_zero", {28'd0, m_busy, m_bclk, m_lrck, m_data}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
        repeat (300) @(posedge clk);
        #1;
        chk("mid_no_frame", frames, 0);
        chk("mid_no_busy", runs + busy_len, 0);
        chk("mid_idle", {28'd0, m_busy, m_bclk, m_lrck, m_data}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
